fetch_unit: RTL

Parametrised instruction-fetch stage for the MIPS pipeline. It owns the PC, issues word reads to a 1-cycle-latency synchronous program memory, buffers returned instructions in a small FIFO, and hands them to decode over a valid/ready handshake. Unlike the single-register fetch it replaces, it supports decode back-pressure, flushes in-flight fetches on redirect, and has a configurable reset vector, width and buffer depth.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: default widths, PC step, NOP word and
// the encoding of why fetch is being redirected.
package mips_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned PC_INC     = 4;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_JUMP = 2'd1,
        REDIR_BEQ  = 2'd2,
        REDIR_BNE  = 2'd3
    } redir_e;

    function automatic redir_e redirect_kind(
        input logic is_jump,
        input logic branch_eq,
        input logic branch_ne,
        input logic is_zero
    );
        redir_e kind;
        kind = REDIR_NONE;
        if (is_jump) begin
            kind = REDIR_JUMP;
        end else if (branch_eq && is_zero) begin
            kind = REDIR_BEQ;
        end else if (branch_ne && !is_zero) begin
            kind = REDIR_BNE;
        end
        return kind;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// First-word-fall-through instruction buffer with synchronous flush and
// occupancy count. DEPTH must be a power of two so pointers wrap freely.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i & ~flush_i;
        do_pop   = pop_i & ~flush_i & (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-gated issue to 1-cycle program memory,
// redirect/kill and FWFT buffer to decode. Option: FETCH_MISALIGN_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       DATA_W     = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              control_is_jump,
    input  logic              control_branch_eq,
    input  logic              control_branch_inc,
    input  logic              control_is_zero,
    input  logic [ADDR_W-1:0] data_jump_address,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
`ifdef FETCH_MISALIGN_EN
    output logic              out_fault,
`endif
    output logic [ADDR_W-1:0] out_iadd
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CRD_W = CNT_W + 1;
    localparam int unsigned ENT_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] target_c;
    logic              redirect_c, halt_c, credit_c, issue_c, push_c, pop_c;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENT_W-1:0]  fifo_rdata;
    logic              fifo_empty;

    assign redirect_c = (redirect_kind(control_is_jump, control_branch_eq,
                                       control_branch_inc, control_is_zero) != REDIR_NONE);

`ifdef FETCH_MISALIGN_EN
    logic fault_q, fault_d;

    assign target_c = data_jump_address;
    assign halt_c   = fault_q;

    // Sticky until the next redirect decides alignment again.
    always_comb begin
        fault_d = fault_q;
        if (redirect_c) fault_d = (data_jump_address[1:0] != 2'b00);
    end

    always_ff @(posedge clock) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign out_fault = fault_q;
`else
    assign target_c = data_jump_address & ~ADDR_W'(3);
    assign halt_c   = 1'b0;
`endif

    // A pop this cycle frees a slot before the new fetch can return.
    assign pop_c    = out_valid & out_ready;
    assign credit_c = (CRD_W'(fifo_count) + CRD_W'(inflight_q))
                    < (CRD_W'(FIFO_DEPTH) + CRD_W'(pop_c));
    assign issue_c  = ~reset & ~redirect_c & credit_c & ~halt_c;
    assign push_c   = inflight_q & ~redirect_c & ~reset;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        if (redirect_c) begin
            pc_d = target_c;
        end else if (issue_c) begin
            pc_d       = pc_q + ADDR_W'(PC_INC);
            tag_d      = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect_c),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i ({imem_data, tag_q}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty)
    );

    assign imem_en         = issue_c;
    assign imem_addr       = pc_q;
    assign out_valid       = ~fifo_empty;
    assign out_instruction = out_valid ? fifo_rdata[ENT_W-1:ADDR_W] : DATA_W'(NOP_WORD);
    assign out_iadd        = out_valid ? fifo_rdata[ADDR_W-1:0] : '0;

endmodule
